convolve_window: RTL and testbench

- Pipelined multiply-accumulate for one output pixel of a 2-D convolution.
- Inputs: one 5x5 window of signed fixed-point pixels and one 5x5 filter of signed fixed-point weights. Output: the saturated dot product, in the same fixed-point format.
- Supports 5x5 and 3x3 kernels, selected per transaction.
- Sits between the window-buffer/line-buffer logic and the per-layer output accumulator in the CNN datapath.

---
 rtl/convolve_window_if.sv | 24 ++
 rtl/convolve_window.sv | 104 ++++++++++
 tb/tb_convolve_window.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/convolve_window_if.sv
// convolve_window_if: transaction bus for the convolution MAC (window/filter in, result out).
// Signals: in_valid, window, filter, filter_size flow toward the MAC; out_valid, value flow back.
// master = window-buffer side driving transactions, slave = the MAC itself.
interface convolve_window_if #(
   parameter int DATA_W = 16,
   parameter int K_MAX  = 5
);
   logic                            in_valid;
   logic [K_MAX*K_MAX*DATA_W-1:0]   window;
   logic [K_MAX*K_MAX*DATA_W-1:0]   filter;
   logic [15:0]                     filter_size;
   logic                            out_valid;
   logic [DATA_W-1:0]               value;

   modport master (
      output in_valid, window, filter, filter_size,
      input  out_valid, value
   );

   modport slave (
      input  in_valid, window, filter, filter_size,
      output out_valid, value
   );
endinterface

// File: rtl/convolve_window.sv
// convolve_window: signed fixed-point MAC producing one saturated 2-D convolution output pixel (5x5 or 3x3 kernel).
// Latency 2 cycles: stage 1 registers masked products, stage 2 sums, scales, saturates and registers the result.
// No backpressure: a transaction may enter every cycle; results leave in issue order, bubbles pass through.
// Ports: clk (rising edge), rst (synchronous, active-high), bus (convolve_window_if.slave).
// Build option CONV_ROUND_EN: round half up before the fractional shift; undefined gives a floor shift.
module convolve_window #(
   parameter int DATA_W    = 16,
   parameter int FRAC_BITS = 11,
   parameter int K_MAX     = 5
) (
   input  logic              clk,
   input  logic              rst,
   convolve_window_if.slave  bus
);

   localparam int N_ELEM  = K_MAX * K_MAX;
   localparam int PROD_W  = 2 * DATA_W;
   // One guard bit beyond log2(N) growth keeps the 25-term sum (plus rounding) from wrapping.
   localparam int ACC_W   = PROD_W + $clog2(N_ELEM) + 1;
   localparam int SMALL_K = 3;
   localparam logic [15:0] SMALL_SEL = 16'd3;

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`ifdef CONV_ROUND_EN
   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC_BITS - 1);
`endif

   // ---------------- stage 1: masked products ----------------
   logic signed [PROD_W-1:0] prod_d [N_ELEM];
   logic signed [PROD_W-1:0] prod_q [N_ELEM];
   logic                     vld1_d, vld1_q;
   logic                     use_3x3;

   always_comb begin
      use_3x3 = (bus.filter_size == SMALL_SEL);
      vld1_d  = bus.in_valid;
      for (int i = 0; i < N_ELEM; i++) begin
         // Product registers only load on valid input; otherwise they keep their contents.
         prod_d[i] = prod_q[i];
         if (bus.in_valid) begin
            if (!use_3x3 || (((i / K_MAX) < SMALL_K) && ((i % K_MAX) < SMALL_K))) begin
               prod_d[i] = PROD_W'($signed(bus.window[i*DATA_W +: DATA_W]))
                         * PROD_W'($signed(bus.filter[i*DATA_W +: DATA_W]));
            end else begin
               prod_d[i] = '0;
            end
         end
      end
   end

   // ---------------- stage 2: sum, scale, saturate ----------------
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] scaled;
   logic [DATA_W-1:0]       sat;
   logic [DATA_W-1:0]       value_d, value_q;
   logic                    out_valid_d, out_valid_q;

   always_comb begin
      acc = '0;
      for (int i = 0; i < N_ELEM; i++) begin
         acc = acc + ACC_W'(prod_q[i]);
      end
`ifdef CONV_ROUND_EN
      acc = acc + RND_HALF;
`endif
      // Arithmetic shift: floors toward negative infinity for negative sums.
      scaled = acc >>> FRAC_BITS;
      if (scaled > SAT_MAX) begin
         sat = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (scaled < SAT_MIN) begin
         sat = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         sat = scaled[DATA_W-1:0];
      end
      out_valid_d = vld1_q;
      // value holds across bubbles.
      value_d     = vld1_q ? sat : value_q;
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         vld1_q      <= 1'b0;
         out_valid_q <= 1'b0;
         value_q     <= '0;
      end else begin
         vld1_q      <= vld1_d;
         out_valid_q <= out_valid_d;
         value_q     <= value_d;
      end
   end

   // Datapath products need no reset: they are qualified by vld1_q.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_ELEM; i++) begin
         prod_q[i] <= prod_d[i];
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.value     = value_q;

endmodule

// File: tb/tb_convolve_window.sv
// tb_convolve_window: directed vectors for convolve_window with a queue-based scoreboard.
// Stimulus pushes hand-computed results; an independent negedge monitor pops and compares on out_valid.
// Idle cycles check that value holds; reset windows check that outputs are cleared and in-flight work is dropped.
module tb_convolve_window;

   localparam int DATA_W = 16;
   localparam int K_MAX  = 5;
   localparam int N      = K_MAX * K_MAX;
   localparam int VEC_W  = N * DATA_W;

`ifdef CONV_ROUND_EN
   localparam logic [15:0] EXP_RND_POS = 16'h0001;
   localparam logic [15:0] EXP_RND_NEG = 16'h0000;
`else
   localparam logic [15:0] EXP_RND_POS = 16'h0000;
   localparam logic [15:0] EXP_RND_NEG = 16'hFFFF;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   convolve_window_if #(.DATA_W(DATA_W), .K_MAX(K_MAX)) bus ();

   convolve_window #(.DATA_W(DATA_W), .FRAC_BITS(11), .K_MAX(K_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [15:0] exp_q  [$];
   string       name_q [$];
   logic [15:0] last_val = '0;
   logic [15:0] mon_exp;
   string       mon_name;

   function automatic logic [VEC_W-1:0] fill(input logic [15:0] v);
      logic [VEC_W-1:0] r;
      for (int i = 0; i < N; i++) r[i*DATA_W +: DATA_W] = v;
      return r;
   endfunction

   function automatic logic [VEC_W-1:0] single(input logic [15:0] v);
      logic [VEC_W-1:0] r;
      r = '0;
      r[DATA_W-1:0] = v;
      return r;
   endfunction

   // Outside the 3x3 block: 0x7FFF; inside: 0.
   function automatic logic [VEC_W-1:0] outside_3x3();
      logic [VEC_W-1:0] r;
      for (int i = 0; i < N; i++)
         r[i*DATA_W +: DATA_W] = ((i / K_MAX) < 3 && (i % K_MAX) < 3) ? 16'h0000 : 16'h7FFF;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic drive(input logic vld, input logic [VEC_W-1:0] w, input logic [VEC_W-1:0] f,
                        input logic [15:0] fs, input logic expect_out, input logic [15:0] ev,
                        input string nm);
      @(posedge clk);
      #1;
      bus.in_valid    = vld;
      bus.window      = w;
      bus.filter      = f;
      bus.filter_size = fs;
      if (vld && expect_out) begin
         exp_q.push_back(ev);
         name_q.push_back(nm);
      end
   endtask

   // Idle cycles present junk data that must not be sampled.
   task automatic idle();
      drive(1'b0, fill(16'h7FFF), fill(16'h7FFF), 16'd3, 1'b0, 16'h0000, "idle");
   endtask

   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 16'(exp_q.size()), 16'd0);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (rst) begin
         last_val = '0;
      end else if (bus.out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%h required=no_output", bus.value);
            last_val = bus.value;
         end else begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            chk(mon_name, bus.value, mon_exp);
            last_val = mon_exp;
         end
      end else begin
         chk("hold_value", bus.value, last_val);
      end
   end

   initial begin
      rst             = 1'b1;
      bus.in_valid    = 1'b1;
      bus.window      = fill(16'h0400);
      bus.filter      = fill(16'h0800);
      bus.filter_size = 16'd5;

      repeat (2) begin
         @(negedge clk);
         chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
         chk("rst_value", bus.value, 16'h0000);
      end
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_out_valid", 16'(bus.out_valid), 16'd0);
         chk("post_rst_value", bus.value, 16'h0000);
      end

      // Back-to-back stream.
      drive(1'b1, fill(16'h0400), fill(16'h0800), 16'd5,     1'b1, 16'h6400, "nom5");
      drive(1'b1, fill(16'h0400), fill(16'h0800), 16'd3,     1'b1, 16'h2400, "nom3");
      drive(1'b1, fill(16'h0400), fill(16'h0800), 16'hFFFF,  1'b1, 16'h6400, "fs_ffff_is_5x5");
      drive(1'b1, fill(16'h0400), fill(16'h0800), 16'h0103,  1'b1, 16'h6400, "fs_0103_is_5x5");
      drive(1'b1, fill(16'h0800), fill(16'h0800), 16'd5,     1'b1, 16'h7FFF, "pos_sat5");
      drive(1'b1, fill(16'h0800), fill(16'h0800), 16'd3,     1'b1, 16'h4800, "pos3");
      drive(1'b1, fill(16'hB000), fill(16'h0800), 16'd5,     1'b1, 16'h8000, "neg_sat5");
      drive(1'b1, fill(16'hB000), fill(16'h0800), 16'd3,     1'b1, 16'h8000, "neg_sat3");
      drive(1'b1, outside_3x3(),  outside_3x3(),  16'd3,     1'b1, 16'h0000, "mask3");
      drive(1'b1, single(16'h0400), single(16'h0001), 16'd5, 1'b1, EXP_RND_POS, "round_pos");
      drive(1'b1, single(16'hFC00), single(16'h0001), 16'd5, 1'b1, EXP_RND_NEG, "round_neg");

      // Bubbles: alternating valid/idle.
      idle();
      drive(1'b1, fill(16'h0400), fill(16'h0800), 16'd5, 1'b1, 16'h6400, "bubble_a");
      idle();
      drive(1'b1, fill(16'h0800), fill(16'h0800), 16'd3, 1'b1, 16'h4800, "bubble_b");
      idle();
      drive(1'b1, fill(16'h0400), fill(16'h0800), 16'd3, 1'b1, 16'h2400, "bubble_c");
      idle();
      idle();
      wait_drain("drain_before_midrst");

      // Reset one cycle after a valid input: that transaction must vanish.
      drive(1'b1, fill(16'h0800), fill(16'h0800), 16'd5, 1'b0, 16'h0000, "dropped");
      @(posedge clk);
      #1;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("midrst_drop_out_valid", 16'(bus.out_valid), 16'd0);
      end

      // Recovery after reset.
      drive(1'b1, fill(16'h0400), fill(16'h0800), 16'd3, 1'b1, 16'h2400, "after_midrst");
      idle();
      wait_drain("final_drain");
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
